// File: rtl/btn_ctrl_pkg.sv
// btn_ctrl_pkg: shared types and helpers for the button gesture controller.
//   state_e   : FSM state enum with fixed 3-bit codes, exported on state_o.
//   ms_to_cyc : milliseconds to clock cycles, evaluated at elaboration.
package btn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ONE      = 3'd1,
    ST_LONG     = 3'd2,
    ST_CHORD    = 3'd3,
    ST_WAIT_REL = 3'd4
  } state_e;

  // Divide first so large CLK_HZ values cannot overflow the 32-bit product.
  function automatic int ms_to_cyc(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/ms_timer.sv
// ms_timer: saturating cycle counter shared by the gesture FSM states.
//   clk, rst : clock, async active-high reset
//   clr      : restart at 0 on the next cycle
//   cmp      : compare value
//   tmr      : current count (0 in the first cycle after clr)
//   hit      : tmr == cmp
module ms_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [TW-1:0] cmp,
  output logic [TW-1:0] tmr,
  output logic          hit
);

  logic [TW-1:0] tmr_q, tmr_d;

  // Saturate so a very long hold can never wrap back into the chord window.
  always_comb begin
    tmr_d = tmr_q;
    if (clr)         tmr_d = '0;
    else if (!(&tmr_q)) tmr_d = tmr_q + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmr_q <= '0;
    else     tmr_q <= tmr_d;
  end

  assign tmr = tmr_q;
  assign hit = (tmr_q == cmp);

endmodule

// File: rtl/btn_cnt_ctrl.sv
// btn_cnt_ctrl: two-button gesture controller owning the LED counter.
//   Actions: short-press step, long-press auto-repeat, two-button chord
//   clear, and wait-for-release after a chord.
//   clk, rst            : clock, async active-high reset
//   b1_press/b1_rel     : button 1 (increment) edge pulses
//   b2_press/b2_rel     : button 2 (decrement) edge pulses
//   b1_level/b2_level   : debounced held levels, 1 = pressed
//   cnt                 : counter value (modulo 2^W)
//   step_evt            : one-cycle pulse with every counter update
//   state_o             : current FSM state code
// Build option: define BTN_AUTOREPEAT_EN to include the LONG auto-repeat
// state; without it, ONE steps only on release of the starting button.
module btn_cnt_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 27_000_000,
  parameter int CHORD_MS  = 50,
  parameter int LONG_MS   = 500,
  parameter int REPEAT_MS = 100,
  parameter int W         = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         b1_press,
  input  logic         b1_rel,
  input  logic         b2_press,
  input  logic         b2_rel,
  input  logic         b1_level,
  input  logic         b2_level,
  output logic [W-1:0] cnt,
  output logic         step_evt,
  output logic [2:0]   state_o
);

  localparam int CHORD_CYC  = ms_to_cyc(CLK_HZ, CHORD_MS);
  localparam int LONG_CYC   = ms_to_cyc(CLK_HZ, LONG_MS);
  localparam int REPEAT_CYC = ms_to_cyc(CLK_HZ, REPEAT_MS);
  localparam int MAX_CYC    = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int TW         = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] CHORD_T = TW'(CHORD_CYC);

  if (CHORD_CYC < 1 || LONG_CYC < 1 || REPEAT_CYC < 1 || CHORD_CYC >= LONG_CYC) begin : g_bad_cfg
    $error("btn_cnt_ctrl: need cycle constants >= 1 and CHORD_CYC < LONG_CYC");
  end

  state_e         state_q, state_d;
  logic           src_q, src_d;     // 0 = button 1 started the gesture
  logic [W-1:0]   cnt_q, cnt_d;
  logic           step_q, step_d;
  logic           tmr_clr;
  logic [TW-1:0]  tmr, tmr_cmp;
  logic           tmr_hit;

  ms_timer #(.TW(TW)) u_tmr (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .cmp (tmr_cmp),
    .tmr (tmr),
    .hit (tmr_hit)
  );

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [TW-1:0] LONG_T = TW'(LONG_CYC - 1);
  localparam logic [TW-1:0] REP_T  = TW'(REPEAT_CYC - 1);
  assign tmr_cmp = (state_q == ST_LONG) ? REP_T : LONG_T;
`else
  logic tmr_hit_unused;
  assign tmr_cmp        = '0;
  assign tmr_hit_unused = tmr_hit;
`endif

  logic         src_rel, oth_press;
  logic [W-1:0] step_val;
  logic         restart;

  assign src_rel   = src_q ? b2_rel   : b1_rel;
  assign oth_press = src_q ? b1_press : b2_press;
  assign step_val  = src_q ? (cnt_q - W'(1)) : (cnt_q + W'(1));

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (b1_press && b2_press) begin
          state_d = ST_CHORD;
          cnt_d   = '0;
          step_d  = 1'b1;
        end else if (b1_press) begin
          state_d = ST_ONE;
          src_d   = 1'b0;
        end else if (b2_press) begin
          state_d = ST_ONE;
          src_d   = 1'b1;
        end
      end
      ST_ONE: begin
        // Release wins over a same-cycle press of the other button.
        if (src_rel) begin
          state_d = ST_IDLE;
          cnt_d   = step_val;
          step_d  = 1'b1;
        end else if (oth_press && (tmr < CHORD_T)) begin
          state_d = ST_CHORD;
          cnt_d   = '0;
          step_d  = 1'b1;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (tmr_hit) begin
          state_d = ST_LONG;
          cnt_d   = step_val;
          step_d  = 1'b1;
        end
`endif
      end
`ifdef BTN_AUTOREPEAT_EN
      ST_LONG: begin
        if (src_rel) begin
          state_d = ST_IDLE;
        end else if (tmr_hit) begin
          cnt_d   = step_val;
          step_d  = 1'b1;
          restart = 1'b1;
        end
      end
`endif
      // Counter was already cleared on the transition into CHORD.
      ST_CHORD: state_d = ST_WAIT_REL;
      ST_WAIT_REL: begin
        if (!b1_level && !b2_level) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tmr_clr = (state_d != state_q) || restart;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= 1'b0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  assign cnt      = cnt_q;
  assign step_evt = step_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_btn_cnt_ctrl.sv
// tb_btn_cnt_ctrl: directed vector table plus hand-written multi-cycle
// sequences for btn_cnt_ctrl (CLK_HZ=1000: chord 4, long 20, repeat 5 cycles).
// Expectations follow BTN_AUTOREPEAT_EN for the long-hold and reset cases.
module tb_btn_cnt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       b1_press, b1_rel, b2_press, b2_rel, b1_level, b2_level;
  logic [5:0] cnt;
  logic       step_evt;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  btn_cnt_ctrl #(
    .CLK_HZ(1000), .CHORD_MS(4), .LONG_MS(20), .REPEAT_MS(5), .W(6)
  ) dut (
    .clk(clk), .rst(rst),
    .b1_press(b1_press), .b1_rel(b1_rel),
    .b2_press(b2_press), .b2_rel(b2_rel),
    .b1_level(b1_level), .b2_level(b2_level),
    .cnt(cnt), .step_evt(step_evt), .state_o(state_o)
  );

  // inp bit order: {b1_press, b1_rel, b2_press, b2_rel, b1_level, b2_level}
  typedef struct packed {
    logic [5:0] inp;
    logic [7:0] n;
    logic [5:0] cnt;
    logic       evt;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic [5:0] inp, input int n,
                             input int c, input logic e, input int s);
    vec_t r;
    r.inp = inp; r.n = 8'(n); r.cnt = 6'(c); r.evt = e; r.st = 3'(s);
    return r;
  endfunction

  task automatic drive(input logic [5:0] inp);
    {b1_press, b1_rel, b2_press, b2_rel, b1_level, b2_level} = inp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int ec, input logic ee, input int es);
    n_cmp++;
    if (cnt !== 6'(ec) || step_evt !== ee || state_o !== 3'(es)) begin
      n_bad++;
      $display("FAIL %s: got cnt=%0d evt=%0b state=%0d, want cnt=%0d evt=%0b state=%0d",
               nm, cnt, step_evt, state_o, ec, ee, es);
    end
  endtask

  task automatic run_vec(input int i);
    for (int c = 0; c < int'(vecs[i].n); c++) begin
      // pulses only in the first cycle of a multi-cycle entry
      drive(c == 0 ? vecs[i].inp : (vecs[i].inp & 6'b000011));
      tick();
    end
    check($sformatf("vec%0d", i), int'(vecs[i].cnt), vecs[i].evt, int'(vecs[i].st));
  endtask

  task automatic short_b1();
    drive(6'b100010); tick();
    drive(6'b000010); tick();
    drive(6'b010000); tick();
    drive(6'b000000); tick();
  endtask

  int n_part_a;
  int exp_c;
  logic exp_e;
  int exp_s;

  initial begin
    rst = 1'b1;
    drive(6'b000000);

    // short presses and wrap: 0 -> 1 -> 0 -> 63
    vecs.push_back(v(6'b100010, 1, 0,  0, 1));
    vecs.push_back(v(6'b000010, 9, 0,  0, 1));
    vecs.push_back(v(6'b010000, 1, 1,  1, 0));
    vecs.push_back(v(6'b000000, 1, 1,  0, 0));
    vecs.push_back(v(6'b001001, 1, 1,  0, 1));
    vecs.push_back(v(6'b000001, 9, 1,  0, 1));
    vecs.push_back(v(6'b000100, 1, 0,  1, 0));
    vecs.push_back(v(6'b001001, 1, 0,  0, 1));
    vecs.push_back(v(6'b000001, 3, 0,  0, 1));
    vecs.push_back(v(6'b000100, 1, 63, 1, 0));
    vecs.push_back(v(6'b000000, 1, 63, 0, 0));
    n_part_a = vecs.size();
    // chord from 10: b2 press 2 cycles after b1 press
    vecs.push_back(v(6'b100010, 1, 10, 0, 1));
    vecs.push_back(v(6'b000010, 1, 10, 0, 1));
    vecs.push_back(v(6'b001011, 1, 0,  1, 3));
    vecs.push_back(v(6'b000011, 1, 0,  0, 4));
    vecs.push_back(v(6'b010001, 1, 0,  0, 4));
    vecs.push_back(v(6'b101011, 1, 0,  0, 4));
    vecs.push_back(v(6'b000110, 1, 0,  0, 4));
    vecs.push_back(v(6'b010000, 1, 0,  0, 0));
    // late second press (tmr 5 >= 4) is ignored; release steps +1
    vecs.push_back(v(6'b100010, 1, 0,  0, 1));
    vecs.push_back(v(6'b000010, 5, 0,  0, 1));
    vecs.push_back(v(6'b001011, 1, 0,  0, 1));
    vecs.push_back(v(6'b000011, 3, 0,  0, 1));
    vecs.push_back(v(6'b010001, 1, 1,  1, 0));
    vecs.push_back(v(6'b000100, 1, 1,  0, 0));
    // same-cycle src release and other press: release wins, press dropped
    vecs.push_back(v(6'b100010, 1, 1,  0, 1));
    vecs.push_back(v(6'b000010, 2, 1,  0, 1));
    vecs.push_back(v(6'b011001, 1, 2,  1, 0));
    vecs.push_back(v(6'b000001, 3, 2,  0, 0));
    vecs.push_back(v(6'b000100, 1, 2,  0, 0));
    // both presses in one IDLE cycle
    vecs.push_back(v(6'b101011, 1, 0,  1, 3));
    vecs.push_back(v(6'b000011, 1, 0,  0, 4));
    vecs.push_back(v(6'b010100, 1, 0,  0, 0));

    tick(); tick();
    check("reset", 0, 1'b0, 0);
    rst = 1'b0;
    tick();
    check("post_reset", 0, 1'b0, 0);

    for (int i = 0; i < n_part_a; i++) run_vec(i);

    for (int k = 0; k < 11; k++) short_b1();
    check("preload_10", 10, 1'b0, 0);

    for (int i = n_part_a; i < vecs.size(); i++) run_vec(i);

    // long hold from cnt=0: steps after cycles 20, 25, 30 of the hold
    drive(6'b100010); tick();
    check("long_k0", 0, 1'b0, 1);
    for (int k = 1; k < 32; k++) begin
      drive(6'b000010); tick();
`ifdef BTN_AUTOREPEAT_EN
      exp_c = (k >= 20 ? 1 : 0) + (k >= 25 ? 1 : 0) + (k >= 30 ? 1 : 0);
      exp_e = (k == 20 || k == 25 || k == 30);
      exp_s = (k >= 20) ? 2 : 1;
`else
      exp_c = 0; exp_e = 1'b0; exp_s = 1;
`endif
      check($sformatf("long_k%0d", k), exp_c, exp_e, exp_s);
    end
    drive(6'b010000); tick();
`ifdef BTN_AUTOREPEAT_EN
    check("long_release", 3, 1'b0, 0);
    exp_c = 4; exp_s = 2;
`else
    check("long_release", 1, 1'b1, 0);
    exp_c = 1; exp_s = 1;
`endif
    drive(6'b000000); tick();

    // reset mid-gesture (LONG when auto-repeat is built in)
    drive(6'b100010); tick();
    for (int k = 1; k < 24; k++) begin
      drive(6'b000010); tick();
    end
    check("pre_reset_hold", exp_c, 1'b0, exp_s);
    #2 rst = 1'b1;
    #1 check("async_reset", 0, 1'b0, 0);
    tick();
    rst = 1'b0;
    drive(6'b010000); tick();
    check("abort_no_step", 0, 1'b0, 0);
    drive(6'b000000); tick();
    check("abort_idle", 0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
